lever_input_conditioner: RTL
============================

// Module: lever_input_conditioner
// PURPOSE
//  Front-end for the tail light controller. Takes the raw, asynchronous brake pedal and
//  turn-lever switch signals, then synchronizes and debounces them. It also resolves
//  conflicting turn requests and drives clean, registered brake/turn_right/turn_left levels.
//  Those levels feed the light controller's inputs directly, and the block emits a
//  one-cycle change strobe.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable synchronized samples needed before an output follows
//                            (10 ms @ 100 MHz); legal range 2..2^24
//  CNT_W            $clog2(DEBOUNCE_CYCLES)  counter width; derived, do not override
// PORTS
//  clk             in   1  100 MHz clock
//  rst             in   1  synchronous reset, active-high
//  brake_raw       in   1  raw brake pedal switch, asynchronous, may bounce
//  turn_right_raw  in   1  raw right lever contact, asynchronous, may bounce
//  turn_left_raw   in   1  raw left lever contact, asynchronous, may bounce
//  brake           out  1  conditioned brake level (registered)
//  turn_right      out  1  conditioned right turn level (registered)
//  turn_left       out  1  conditioned left turn level (registered)
//  inputs_changed  out  1  1-cycle pulse: {brake,turn_right,turn_left} differs from previous cycle
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all sync flops, debounced levels, counters, ownership and outputs <= 0.
//    inputs_changed=0 during reset and on the first cycle after reset.
//  - Synchronizer: each raw input passes through 2 flops (s1, s2). No logic between s1 and s2.
//  - Debounce, per channel, one CNT_W-bit counter cnt and one level db. At each posedge:
//      s2 == db                   -> cnt <= 0
//      s2 != db, cnt < DEBOUNCE_CYCLES-1  -> cnt <= cnt+1
//      s2 != db, cnt == DEBOUNCE_CYCLES-1 -> db <= s2, cnt <= 0
//    A glitch shorter than DEBOUNCE_CYCLES samples never reaches db. Any return to the db level restarts the count.
//  - Latency: if a new raw level is first sampled at edge 0 and held, db changes at edge DEBOUNCE_CYCLES+1.
//  - Each channel is a 4-state FSM: STABLE_LO, PEND_HI (counting), STABLE_HI, PEND_LO.
//    A PEND_* state aborts back to its STABLE_* state when s2 returns.
//  - brake = db_brake, with no further logic.
//  - Turn conflict resolution: output registers are updated from the db values on the same edge that db changes.
//      only db_r=1 -> turn_right=1, turn_left=0
//      only db_l=1 -> turn_left=1,  turn_right=0
//      neither     -> both 0
//      both        -> see CONFIGURATION
//  - Outputs never both assert turn_right and turn_left in the same cycle.
//  - inputs_changed: asserted for exactly the one cycle in which the new output value is first visible.
//    Several outputs changing on the same edge produce one pulse. Changes on consecutive edges give back-to-back pulses.
//  - A reset mid-debounce discards the pending count. Outputs return to 0 and do not resume.
// CONFIGURATION
//  LEVER_INTERLOCK_EN defined: a 2-bit owner register {NONE, RIGHT, LEFT} holds the lever that asserted first.
//    - While the owner's db stays 1, the other side's db rising is ignored and the owner's output stays 1.
//    - When the owner's db falls and the other db=1, ownership and output switch to the other side on that same edge.
//    - If both db values rise on the same edge, owner stays NONE and both outputs stay 0 until one side drops.
//  LEVER_INTERLOCK_EN undefined: no owner register. Whenever db_r=db_l=1, both turn outputs are 0.
//    Outputs follow the single-side rules as soon as only one db remains high.
// TESTING (bench overrides DEBOUNCE_CYCLES=4)
//  1. rst held 3 cycles with all raw=1 -> all outputs 0, inputs_changed 0. Release: brake rises at edge 5 after release, with one pulse.
//  2. turn_left_raw 0->1 sampled at edge 0, held -> turn_left=1 after edge 5 and inputs_changed=1 for one cycle.
//     turn_right stays 0 throughout.
//  3. brake_raw bounce 1,1,1,0,1,1,1 (3-cycle runs) -> brake never asserts. A following 4-sample-stable 1 asserts brake 5 edges after its first sample.
//  4. Established right turn, then turn_left_raw=1 held:
//     - LEVER_INTERLOCK_EN defined: turn_right stays 1, turn_left 0.
//     - Undefined: both 0 after left debounce, with one pulse.
//  5. Interlock build, right owner, release turn_right_raw with left still high -> turn_left=1 on the same edge turn_right=0, one pulse.
//  6. brake_raw and turn_right_raw rise on the same cycle -> both outputs change on the same edge, single inputs_changed pulse.
//     Assert rst mid-count -> both cleared, no late update.

Source files
------------

// File: rtl/lever_input_conditioner.sv
// Brake / turn-lever front end: 2-flop sync, per-channel debounce FSM, turn conflict resolution.
// Optional build macro LEVER_INTERLOCK_EN: first-asserted lever keeps ownership of the turn outputs.
module lever_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic brake_raw,
  input  logic turn_right_raw,
  input  logic turn_left_raw,
  output logic brake,
  output logic turn_right,
  output logic turn_left,
  output logic inputs_changed
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  // channel index: 0 brake, 1 right, 2 left
  logic [2:0] raw_s;
  logic [2:0] s1_r;
  logic [2:0] s2_r;
  logic [2:0] db_nxt_s;
  logic       turn_right_nxt_s;
  logic       turn_left_nxt_s;

  assign raw_s = {turn_left_raw, turn_right_raw, brake_raw};

  // Two-flop synchronizer for all raw contacts
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 3'b000;
      s2_r <= 3'b000;
    end else begin
      s1_r <= raw_s;
      s2_r <= s1_r;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_db
    db_state_t        state_r;
    db_state_t        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             db_nxt_ch_s;

    // Debounce state and counter register
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= STABLE_LO;
        cnt_r   <= CNT_ZERO;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
      end
    end

    // Next state: count mismatching samples, commit on the last one, abort on return
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = CNT_ZERO;
      case (state_r)
        STABLE_LO: begin
          if (s2_r[ch]) begin
            state_nxt_s = PEND_HI;
            cnt_nxt_s   = CNT_ONE;
          end else begin
            state_nxt_s = STABLE_LO;
          end
        end
        PEND_HI: begin
          if (!s2_r[ch]) begin
            state_nxt_s = STABLE_LO;
          end else if (cnt_r == CNT_MAX) begin
            state_nxt_s = STABLE_HI;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s2_r[ch]) begin
            state_nxt_s = PEND_LO;
            cnt_nxt_s   = CNT_ONE;
          end else begin
            state_nxt_s = STABLE_HI;
          end
        end
        PEND_LO: begin
          if (s2_r[ch]) begin
            state_nxt_s = STABLE_HI;
          end else if (cnt_r == CNT_MAX) begin
            state_nxt_s = STABLE_LO;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = STABLE_LO;
        end
      endcase
    end

    // Debounced level as it will be after this edge, so outputs register in step with it
    always_comb begin
      db_nxt_ch_s = (state_nxt_s == STABLE_HI) || (state_nxt_s == PEND_LO);
    end

    assign db_nxt_s[ch] = db_nxt_ch_s;
  end

`ifdef LEVER_INTERLOCK_EN
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_RIGHT = 2'd1;
  localparam logic [1:0] OWN_LEFT  = 2'd2;

  logic [1:0] owner_r;
  logic [1:0] owner_nxt_s;

  // Ownership: a single active side owns; with both active the current owner (or nobody) holds
  always_comb begin
    owner_nxt_s = owner_r;
    case ({db_nxt_s[1], db_nxt_s[2]})
      2'b00:   owner_nxt_s = OWN_NONE;
      2'b10:   owner_nxt_s = OWN_RIGHT;
      2'b01:   owner_nxt_s = OWN_LEFT;
      2'b11:   owner_nxt_s = owner_r;
      default: owner_nxt_s = OWN_NONE;
    endcase
    turn_right_nxt_s = (owner_nxt_s == OWN_RIGHT);
    turn_left_nxt_s  = (owner_nxt_s == OWN_LEFT);
  end

  // Owner register
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_NONE;
    end else begin
      owner_r <= owner_nxt_s;
    end
  end
`else
  // Conflicting requests blank both turn outputs
  always_comb begin
    turn_right_nxt_s = db_nxt_s[1] & ~db_nxt_s[2];
    turn_left_nxt_s  = db_nxt_s[2] & ~db_nxt_s[1];
  end
`endif

  // Registered outputs and change strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      brake          <= 1'b0;
      turn_right     <= 1'b0;
      turn_left      <= 1'b0;
      inputs_changed <= 1'b0;
    end else begin
      brake          <= db_nxt_s[0];
      turn_right     <= turn_right_nxt_s;
      turn_left      <= turn_left_nxt_s;
      inputs_changed <= ({db_nxt_s[0], turn_right_nxt_s, turn_left_nxt_s} !=
                         {brake, turn_right, turn_left});
    end
  end

endmodule
